// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a single-port
//            synchronous memory. A grant lasts up to BURST_MAX consecutive
//            beats; read data is returned to the requester that issued the
//            read, one cycle after the memory access.
// Ports    : clk, rstn                     clock, async active-low reset
//            s0_*/s1_* valid/ready/addr/wdata/we   requester beat channels
//            s0_*/s1_* rdata/rvalid        read return (rvalid one-cycle pulse)
//            m_en/m_addr/m_din/m_we        memory request (combinational mux)
//            m_dout                        memory read data (one-cycle latency)
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [31:0]           s0_wdata,
    input  logic [3:0]            s0_we,
    output logic [31:0]           s0_rdata,
    output logic                  s0_rvalid,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [31:0]           s1_wdata,
    input  logic [3:0]            s1_we,
    output logic [31:0]           s1_rdata,
    output logic                  s1_rvalid,
    output logic                  m_en,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [31:0]           m_din,
    output logic [3:0]            m_we,
    input  logic [31:0]           m_dout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    localparam logic [3:0] C_CNT_LAST = 4'(BURST_MAX - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       r_rvalid0;
    logic       r_rvalid1;

    logic       w_acc0;
    logic       w_acc1;
    logic       w_acc;
    logic       w_own_is1;
    logic       w_own_valid;
    logic       w_oth_valid;
    logic       w_end;

    // Ready is only ever granted to the current owner, so both can never be
    // high together and IDLE never accepts.
    assign w_acc0   = (r_state == S_OWN0) && s0_valid;
    assign w_acc1   = (r_state == S_OWN1) && s1_valid;
    assign w_acc    = w_acc0 | w_acc1;
    assign s0_ready = w_acc0;
    assign s1_ready = w_acc1;

    assign m_en   = w_acc;
    assign m_addr = w_acc1 ? s1_addr  : s0_addr;
    assign m_din  = w_acc1 ? s1_wdata : s0_wdata;
    assign m_we   = w_acc0 ? s0_we : (w_acc1 ? s1_we : 4'b0000);

    // Memory data is broadcast; rvalid qualifies which requester owns it.
    assign s0_rdata  = m_dout;
    assign s1_rdata  = m_dout;
    assign s0_rvalid = r_rvalid0;
    assign s1_rvalid = r_rvalid1;

    // Owner-relative view of the two valids (only meaningful in OWN states).
    assign w_own_is1   = (r_state == S_OWN1);
    assign w_own_valid = w_own_is1 ? s1_valid : s0_valid;
    assign w_oth_valid = w_own_is1 ? s0_valid : s1_valid;

    // Grant ends when the owner drops valid or its final allowed beat goes.
    assign w_end = !w_own_valid || (w_acc && (r_cnt == C_CNT_LAST));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            // Read-return tag is captured at acceptance, independent of any
            // grant change happening on the same edge.
            r_rvalid0 <= w_acc0 && (s0_we == 4'b0000);
            r_rvalid1 <= w_acc1 && (s1_we == 4'b0000);

            case (r_state)
                S_IDLE: begin
                    // With both pending, the requester not served last wins.
                    if (s0_valid && (!s1_valid || r_last)) begin
                        r_state <= S_OWN0;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b0;
                    end else if (s1_valid) begin
                        r_state <= S_OWN1;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b1;
                    end
                end
                S_OWN0, S_OWN1: begin
                    if (w_end) begin
                        r_cnt <= 4'd0;
                        if (w_oth_valid) begin
                            r_state <= w_own_is1 ? S_OWN0 : S_OWN1;
                            r_last  <= !w_own_is1;
                        end else if (!w_own_valid) begin
                            r_state <= S_IDLE;
                        end
                        // else: owner keeps the grant and starts a new burst
                    end else if (w_acc) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
